// File: rtl/id_stage_pipe.sv
// Pipelined decode stage: decodes a 16-bit instruction, reads the register file with
// write-back bypass, stalls on load-use hazards and issues a registered ID/EX bundle.
module id_stage_pipe #(
    parameter int DWIDTH  = 16,
    parameter int AWIDTH  = 4,
    parameter bit R0_ZERO = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       in_instr,
    input  logic [DWIDTH-1:0] in_pc,
    input  logic              flush,
    input  logic              wb_en,
    input  logic [AWIDTH-1:0] wb_addr,
    input  logic [DWIDTH-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        out_opcode,
    output logic [AWIDTH-1:0] out_rd,
    output logic [DWIDTH-1:0] out_src1,
    output logic [DWIDTH-1:0] out_src2,
    output logic [DWIDTH-1:0] out_imm,
    output logic [DWIDTH-1:0] out_pc,
    output logic [5:0]        out_ctrl,
    output logic              halted
);

    localparam int DEPTH = 2 ** AWIDTH;

    logic [DWIDTH-1:0] rf [DEPTH];

    logic [3:0]        opcode;
    logic [AWIDTH-1:0] rd_addr;
    logic [AWIDTH-1:0] rs_addr;
    logic [AWIDTH-1:0] rt_addr;
    logic [AWIDTH-1:0] src_addr [2];
    logic [DWIDTH-1:0] src_data [2];
    logic [1:0]        src_used;
    logic [DWIDTH-1:0] imm;
    logic [5:0]        ctrl;
    logic              hazard;
    logic              accept;

    assign opcode  = in_instr[15:12];
    assign rd_addr = AWIDTH'(in_instr[11:8]);
    assign rs_addr = AWIDTH'(in_instr[7:4]);
    assign rt_addr = AWIDTH'(in_instr[3:0]);

    // LLB/LHB modify rd in place, SW stores rd: both pull rd onto a source port.
    assign src_addr[0] = (opcode == 4'hA || opcode == 4'hB) ? rd_addr : rs_addr;
    assign src_addr[1] = (opcode == 4'h9) ? rd_addr : rt_addr;

    assign src_used[0] = (opcode <= 4'hB) || (opcode == 4'hD);
    assign src_used[1] = (opcode <= 4'h3) || (opcode == 4'h7) || (opcode == 4'h9);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_read
            assign src_data[gi] = (R0_ZERO && src_addr[gi] == '0) ? '0 :
                                  (wb_en && wb_addr == src_addr[gi]) ? wb_data :
                                  rf[src_addr[gi]];
        end
    endgenerate

    always_comb begin
        imm = '0;
        case (opcode)
            4'h4, 4'h5, 4'h6: imm = DWIDTH'(in_instr[3:0]);
            4'h8, 4'h9:       imm = {{(DWIDTH-5){in_instr[3]}}, in_instr[3:0], 1'b0};
            4'hA, 4'hB:       imm = DWIDTH'(in_instr[7:0]);
            4'hC:             imm = {{(DWIDTH-10){in_instr[8]}}, in_instr[8:0], 1'b0};
            default:          imm = '0;
        endcase
    end

    // {regwrite, memread, memwrite, memtoreg, branch, halt}
    always_comb begin
        ctrl    = '0;
        ctrl[5] = (opcode <= 4'h8) || (opcode == 4'hA) || (opcode == 4'hB) || (opcode == 4'hE);
        ctrl[4] = (opcode == 4'h8);
        ctrl[3] = (opcode == 4'h9);
        ctrl[2] = (opcode == 4'h8);
        ctrl[1] = (opcode == 4'hC) || (opcode == 4'hD);
        ctrl[0] = (opcode == 4'hF);
    end

    assign hazard = out_valid && out_ctrl[4] && (out_rd != '0) &&
                    ((src_used[0] && out_rd == src_addr[0]) ||
                     (src_used[1] && out_rd == src_addr[1]));

    assign in_ready = !(out_valid && !out_ready) && !hazard && !flush && !halted;
    assign accept   = in_valid && in_ready;

    // Write-back is never blocked by stall, flush or halt.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                rf[i] <= '0;
            end
        end else if (wb_en && !(R0_ZERO && wb_addr == '0)) begin
            rf[wb_addr] <= wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid  <= 1'b0;
            out_opcode <= '0;
            out_rd     <= '0;
            out_src1   <= '0;
            out_src2   <= '0;
            out_imm    <= '0;
            out_pc     <= '0;
            out_ctrl   <= '0;
            halted     <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid  <= 1'b1;
            out_opcode <= opcode;
            out_rd     <= rd_addr;
            out_src1   <= src_data[0];
            out_src2   <= src_data[1];
            out_imm    <= imm;
            out_pc     <= in_pc;
            out_ctrl   <= ctrl;
            if (opcode == 4'hF) begin
                halted <= 1'b1;
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed testbench for id_stage_pipe: reset, bypass, load-use, backpressure,
// decode table, flush and halt/R0 scenarios with hand-computed expectations.
module tb_id_stage_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_instr;
    logic [15:0] in_pc;
    logic        flush;
    logic        wb_en;
    logic [3:0]  wb_addr;
    logic [15:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_opcode;
    logic [3:0]  out_rd;
    logic [15:0] out_src1;
    logic [15:0] out_src2;
    logic [15:0] out_imm;
    logic [15:0] out_pc;
    logic [5:0]  out_ctrl;
    logic        halted;

    int errors = 0;
    int checks = 0;

    id_stage_pipe #(.DWIDTH(16), .AWIDTH(4), .R0_ZERO(1'b1)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
        .out_rd(out_rd), .out_src1(out_src1), .out_src2(out_src2), .out_imm(out_imm),
        .out_pc(out_pc), .out_ctrl(out_ctrl), .halted(halted)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b expected 0", halted); end
        rst = 1'b1;
        // Load R5 via write-back while issuing a reader of R5.
        in_valid = 1'b1; in_instr = 16'h0150; in_pc = 16'h0002;
        wb_en = 1'b1; wb_addr = 4'd5; wb_data = 16'hBEEF;
        tick();
        $display("txn reset: ADD R1,R5,R0 issued src1=%h", out_src1);
        checks++; if (out_src1 !== 16'hBEEF) begin errors++; $display("FAIL reset_pre_src1: got %h expected beef", out_src1); end
        in_valid = 1'b0; wb_en = 1'b0; out_ready = 1'b0;
        #3 rst = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL async_reset_valid: got %b expected 0", out_valid); end
        checks++; if (out_src1 !== 16'h0000) begin errors++; $display("FAIL async_reset_src1: got %h expected 0000", out_src1); end
        #2 rst = 1'b1;
        tick();
        out_ready = 1'b1;
        in_valid = 1'b1; in_instr = 16'h0150; in_pc = 16'h0004;
        tick();
        $display("txn reset: read R5 after reset src1=%h", out_src1);
        checks++; if (out_src1 !== 16'h0000) begin errors++; $display("FAIL reset_r5: got %h expected 0000", out_src1); end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_bypass();
        in_valid = 1'b1; in_instr = 16'h0133; in_pc = 16'h0010;
        wb_en = 1'b1; wb_addr = 4'd3; wb_data = 16'h1234;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bypass_ready: got %b expected 1", in_ready); end
        tick();
        in_valid = 1'b0; wb_en = 1'b0;
        $display("txn bypass: ADD R1,R3,R3 src1=%h src2=%h ctrl=%b", out_src1, out_src2, out_ctrl);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bypass_valid: got %b expected 1", out_valid); end
        checks++; if (out_src1 !== 16'h1234) begin errors++; $display("FAIL bypass_src1: got %h expected 1234", out_src1); end
        checks++; if (out_src2 !== 16'h1234) begin errors++; $display("FAIL bypass_src2: got %h expected 1234", out_src2); end
        checks++; if (out_ctrl !== 6'b100000) begin errors++; $display("FAIL bypass_ctrl: got %b expected 100000", out_ctrl); end
        checks++; if (out_rd !== 4'd1) begin errors++; $display("FAIL bypass_rd: got %h expected 1", out_rd); end
        checks++; if (out_pc !== 16'h0010) begin errors++; $display("FAIL bypass_pc: got %h expected 0010", out_pc); end
        tick();
    endtask

    task automatic test_load_use();
        in_valid = 1'b1; in_instr = 16'h8241; in_pc = 16'h0020;
        tick();
        $display("txn load_use: LW R2,R4,1 ctrl=%b imm=%h", out_ctrl, out_imm);
        checks++; if (out_ctrl !== 6'b110100) begin errors++; $display("FAIL lw_ctrl: got %b expected 110100", out_ctrl); end
        checks++; if (out_imm !== 16'h0002) begin errors++; $display("FAIL lw_imm: got %h expected 0002", out_imm); end
        in_instr = 16'h0627; in_pc = 16'h0022;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hazard_ready: got %b expected 0", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bubble_valid: got %b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL after_bubble_ready: got %b expected 1", in_ready); end
        tick();
        $display("txn load_use: ADD R6,R2,R7 issued valid=%b rd=%h", out_valid, out_rd);
        checks++; if (out_valid !== 1'b1 || out_rd !== 4'd6 || out_pc !== 16'h0022) begin
            errors++; $display("FAIL add_issue: got valid=%b rd=%h pc=%h expected 1/6/0022", out_valid, out_rd, out_pc);
        end
        // Load into R0 never stalls a consumer of R0.
        in_instr = 16'h8041; in_pc = 16'h0024;
        tick();
        in_instr = 16'h0607; in_pc = 16'h0026;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL lw_r0_ready: got %b expected 1", in_ready); end
        tick();
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 16'h1123; in_pc = 16'h0030;
        tick();
        in_instr = 16'h2456; in_pc = 16'h0032;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_opcode !== 4'h1 || out_pc !== 16'h0030) begin
                errors++; $display("FAIL hold_%0d: got ready=%b valid=%b op=%h pc=%h expected 0/1/1/0030", i, in_ready, out_valid, out_opcode, out_pc);
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_ready: got %b expected 1", in_ready); end
        tick();
        in_valid = 1'b0;
        $display("txn backpressure: XOR issued op=%h pc=%h", out_opcode, out_pc);
        checks++; if (out_valid !== 1'b1 || out_opcode !== 4'h2 || out_pc !== 16'h0032) begin
            errors++; $display("FAIL release_issue: got valid=%b op=%h pc=%h expected 1/2/0032", out_valid, out_opcode, out_pc);
        end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL no_duplicate: got %b expected 0", out_valid); end
    endtask

    task automatic test_decode();
        logic [15:0] instrs [6];
        logic [15:0] imms [6];
        logic [5:0]  ctrls [6];
        instrs = '{16'h412F, 16'h9128, 16'hA3AB, 16'hC0FF, 16'hC1FF, 16'hE123};
        imms   = '{16'h000F, 16'hFFF0, 16'h00AB, 16'h01FE, 16'hFFFE, 16'h0000};
        ctrls  = '{6'b100000, 6'b001000, 6'b100000, 6'b000010, 6'b000010, 6'b100000};
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; in_instr = instrs[i]; in_pc = 16'h0040 + 16'(2 * i);
            tick();
            $display("txn decode: instr=%h imm=%h ctrl=%b src1=%h", instrs[i], out_imm, out_ctrl, out_src1);
            checks++; if (out_imm !== imms[i] || out_ctrl !== ctrls[i]) begin
                errors++; $display("FAIL decode_%h: got imm=%h ctrl=%b expected %h/%b", instrs[i], out_imm, out_ctrl, imms[i], ctrls[i]);
            end
            if (instrs[i][15:12] == 4'hA) begin
                checks++; if (out_src1 !== 16'h1234) begin errors++; $display("FAIL llb_src1_rd: got %h expected 1234", out_src1); end
            end
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_flush();
        in_valid = 1'b1; in_instr = 16'h0133; in_pc = 16'h0050;
        tick();
        in_instr = 16'hF000; in_pc = 16'h0052; flush = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b expected 0", in_ready); end
        tick();
        flush = 1'b0; in_valid = 1'b0;
        $display("txn flush: valid=%b halted=%b", out_valid, halted);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b expected 0", out_valid); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL flush_halted: got %b expected 0", halted); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_dropped: got %b expected 0", out_valid); end
    endtask

    task automatic test_halt_r0();
        in_valid = 1'b1; in_instr = 16'h1011; in_pc = 16'h0060;
        wb_en = 1'b1; wb_addr = 4'd0; wb_data = 16'hFFFF;
        tick();
        in_instr = 16'h0200; in_pc = 16'h0062;
        tick();
        $display("txn halt: ADD R2,R0,R0 with wb R0 src1=%h src2=%h", out_src1, out_src2);
        checks++; if (out_src1 !== 16'h0000 || out_src2 !== 16'h0000) begin
            errors++; $display("FAIL r0_bypass: got %h/%h expected 0000/0000", out_src1, out_src2);
        end
        wb_en = 1'b0;
        tick();
        checks++; if (out_src1 !== 16'h0000) begin errors++; $display("FAIL r0_stored: got %h expected 0000", out_src1); end
        in_instr = 16'hF000; in_pc = 16'h0066;
        tick();
        $display("txn halt: HLT issued ctrl=%b halted=%b", out_ctrl, halted);
        checks++; if (out_valid !== 1'b1 || out_ctrl !== 6'b000001 || out_opcode !== 4'hF) begin
            errors++; $display("FAIL hlt_bundle: got valid=%b ctrl=%b op=%h expected 1/000001/f", out_valid, out_ctrl, out_opcode);
        end
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halted_set: got %b expected 1", halted); end
        in_instr = 16'h0133; in_pc = 16'h0068;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL halted_ready: got %b expected 0", in_ready); end
        repeat (2) tick();
        checks++; if (out_valid !== 1'b0 || halted !== 1'b1) begin
            errors++; $display("FAIL frozen: got valid=%b halted=%b expected 0/1", out_valid, halted);
        end
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; flush = 1'b0;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0; out_ready = 1'b1;
        test_reset();
        test_bypass();
        test_load_use();
        test_backpressure();
        test_decode();
        test_flush();
        test_halt_r0();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
